// File: rtl/led_chaser_array.sv
// NCH independent LED chaser channels (rotate left/right, bounce, bar-fill) sharing one tick prescaler.
// Optional build macro CHASE_STAGGER_EN: channel k loads its init pattern advanced by k steps.
module led_chaser_array #(
    parameter int unsigned NCH      = 3,
    parameter int unsigned LED_W    = 8,
    parameter int unsigned TICK_DIV = 12000000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NCH-1:0]       sel,
    input  logic [NCH-1:0]         en,
    output logic [NCH*LED_W-1:0]   led,
    output logic                   tick
);

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BAR    = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LED_W-1:0] ONE_LSB  = LED_W'(1);
    localparam logic [LED_W-1:0] ONE_MSB  = {1'b1, {(LED_W-1){1'b0}}};

    logic [CNT_W-1:0] cnt;

    // Shared prescaler; tick is high for the cycle after the counter's last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_LAST);
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // One pattern step; state is packed as {dir, pat}.
    function automatic logic [LED_W:0] step_state(input mode_e m, input logic [LED_W:0] s);
        logic [LED_W-1:0] p;
        logic             d;
        logic [LED_W-1:0] np;
        logic             nd;
        p  = s[LED_W-1:0];
        d  = s[LED_W];
        np = p;
        nd = d;
        case (m)
            MODE_ROTL:   np = {p[LED_W-2:0], p[LED_W-1]};
            MODE_ROTR:   np = {p[0], p[LED_W-1:1]};
            MODE_BOUNCE: begin
                nd = p[LED_W-1] ? 1'b0 : (p[0] ? 1'b1 : d);
                np = nd ? (p << 1) : (p >> 1);
            end
            MODE_BAR:    np = (&p) ? '0 : {p[LED_W-2:0], 1'b1};
            default:     np = p;
        endcase
        return {nd, np};
    endfunction

    // Initial state of a mode, optionally advanced by a fixed number of steps.
    function automatic logic [LED_W:0] init_state(input mode_e m, input int unsigned adv);
        logic [LED_W:0] s;
        case (m)
            MODE_ROTL:   s = {1'b1, ONE_LSB};
            MODE_ROTR:   s = {1'b1, ONE_MSB};
            MODE_BOUNCE: s = {1'b1, ONE_LSB};
            default:     s = {1'b1, {LED_W{1'b0}}};
        endcase
        for (int unsigned i = 0; i < adv; i++) begin
            s = step_state(m, s);
        end
        return s;
    endfunction

    for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
`ifdef CHASE_STAGGER_EN
        localparam int unsigned ADV = k;
`else
        localparam int unsigned ADV = 0;
`endif
        mode_e            mode_q;
        mode_e            sel_k;
        logic [LED_W-1:0] pat;
        logic             dir;
        logic [LED_W:0]   init_s;
        logic [LED_W:0]   step_s;

        assign sel_k  = mode_e'(sel[2*k +: 2]);
        assign init_s = init_state(sel_k, ADV);
        assign step_s = step_state(mode_q, {dir, pat});

        // A mode change reloads the init pattern and wins over a coincident step.
        always_ff @(posedge clk) begin
            mode_q <= sel_k;
            if (rst || (sel_k != mode_q)) begin
                {dir, pat} <= init_s;
            end else if (tick && en[k]) begin
                {dir, pat} <= step_s;
            end
        end

        assign led[k*LED_W +: LED_W] = pat;
    end

endmodule

// File: tb/tb_led_chaser_array.sv
// Scoreboard bench for led_chaser_array: a phase-index reference model feeds an expected queue.
// Honours CHASE_STAGGER_EN when the same macro is defined for the build.
module tb_led_chaser_array;

    localparam int unsigned NCH      = 3;
    localparam int unsigned LED_W    = 8;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LW       = NCH * LED_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*NCH-1:0]  sel;
    logic [NCH-1:0]    en;
    logic [LW-1:0]     led;
    logic              tick;

    always #5 clk = ~clk;

    led_chaser_array #(
        .NCH(NCH), .LED_W(LED_W), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .led(led), .tick(tick)
    );

    typedef struct packed {
        logic          tick;
        logic [LW-1:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   active = 1'b0;

    // Reference model: each channel is a mode plus a phase index within that mode's period.
    int m_cnt;
    bit m_tick;
    int m_mode [NCH];
    int m_ph   [NCH];

    function automatic int period(input int m);
        case (m)
            0, 1:    return LED_W;
            2:       return 2*LED_W - 2;
            default: return LED_W + 1;
        endcase
    endfunction

    function automatic logic [LED_W-1:0] pattern(input int m, input int ph);
        logic [LED_W-1:0] one;
        one = 1;
        case (m)
            0:       return one << ph;
            1:       return one << (LED_W - 1 - ph);
            2:       return one << ((ph < LED_W) ? ph : (2*LED_W - 2 - ph));
            default: return (one << ph) - 1;
        endcase
    endfunction

    function automatic int init_ph(input int k, input int m);
`ifdef CHASE_STAGGER_EN
        return k % period(m);
`else
        return 0;
`endif
    endfunction

    function automatic logic [LW-1:0] model_led();
        logic [LW-1:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) v[k*LED_W +: LED_W] = pattern(m_mode[k], m_ph[k]);
        return v;
    endfunction

    task automatic model_edge();
        bit old_tick;
        int s;
        if (rst) begin
            m_cnt  = 0;
            m_tick = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                m_mode[k] = int'(sel[2*k +: 2]);
                m_ph[k]   = init_ph(k, m_mode[k]);
            end
        end else begin
            old_tick = m_tick;
            m_tick   = (m_cnt == TICK_DIV - 1);
            m_cnt    = (m_cnt + 1) % TICK_DIV;
            for (int k = 0; k < NCH; k++) begin
                s = int'(sel[2*k +: 2]);
                if (s != m_mode[k]) begin
                    m_mode[k] = s;
                    m_ph[k]   = init_ph(k, s);
                end else if (old_tick && en[k]) begin
                    m_ph[k] = (m_ph[k] + 1) % period(s);
                end
            end
        end
    endtask

    // One clock: model follows the edge, expectation queued, return at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        exp_q.push_back({m_tick, model_led()});
        active = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a new led/tick pair, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (active) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({tick, led} !== e) begin
                        errors++;
                        $display("FAIL chaser at %0t: got tick=%0b led=%h, expected tick=%0b led=%h",
                                 $time, tick, led, e.tick, e.led);
                    end
                end
            end
        end
    end

    initial begin
        logic [LW-1:0] exp_rst;
        logic [LW-1:0] exp_step;
        logic [LW-1:0] exp_zero;
        int            n;
`ifdef CHASE_STAGGER_EN
        exp_rst  = 24'h03_02_01;
        exp_step = 24'h07_04_02;
        exp_zero = 24'h04_02_01;
`else
        exp_rst  = 24'h00_01_01;
        exp_step = 24'h01_02_02;
        exp_zero = 24'h01_01_01;
`endif
        rst = 1'b1;
        sel = 6'b11_10_00;
        en  = 3'b111;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_led", 32'(led), 32'(exp_rst));
        chk("reset_tick", 32'(tick), 32'd0);
        repeat (4) cyc();
        chk("tick_on_4th", 32'(tick), 32'd1);
        chk("led_before_step", 32'(led), 32'(exp_rst));
        cyc();
        chk("first_step", 32'(led), 32'(exp_step));
        chk("tick_one_cycle", 32'(tick), 32'd0);

        // Mode change on a tick cycle: reload wins over the step.
        n = 0;
        while (!m_tick && n < 20) begin
            cyc();
            n++;
        end
        chk("tick_wait_bound", 32'(m_tick), 32'd1);
        sel[1:0] = 2'b01;
        cyc();
        chk("modechg_over_step", 32'(led[7:0]), 32'h80);

        // Long bounce and bar runs to reach the ends of both patterns.
        sel = 6'b10_10_10;
        repeat (70) cyc();
        sel = 6'b11_11_11;
        repeat (50) cyc();

        // Reset mid-run with all channels in rotate-left.
        sel = '0;
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrun_reset_led", 32'(led), 32'(exp_zero));
        chk("midrun_reset_tick", 32'(tick), 32'd0);
        repeat (4) cyc();
        chk("cnt_restart_tick", 32'(tick), 32'd1);

        // Randomised modes, enables and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 300) == 0;
            for (int k = 0; k < NCH; k++) begin
                if (($urandom % 150) == 0) sel[2*k +: 2] = 2'($urandom % 4);
                en[k] = ($urandom % 6) != 0;
            end
            cyc();
        end
        rst = 1'b0;
        cyc();
        active = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
